uart_tx: RTL and testbench

- 8N1 UART transmitter, the transmit end of the serial link whose bit period is set by the top-level `clk_per_bit` bus (`{uio_in[7:0], 2'b00}`).
- Serialises bytes handed over by core logic onto a single line: start bit, 8 data bits LSB first, 1 stop bit.
- A one-entry holding buffer lets the next byte be accepted while the current frame shifts out, so consecutive frames run back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter with a one-entry holding buffer so
//            consecutive frames run back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CPB_W  = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CPB_W-1:0]  clk_per_bit,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int c_bit_w = $clog2(DATA_W + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  r_buf;
    logic               r_buf_full;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [CPB_W-1:0]   r_baud_cnt;
    logic [CPB_W-1:0]   r_period;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               w_bit_end;
    logic               w_last_bit;
    logic               w_can_load;
    logic               w_load;
    logic               w_accept;

    // r_period is only meaningful outside IDLE, where it is always nonzero
    assign w_bit_end  = (r_baud_cnt == (r_period - CPB_W'(1)));
    assign w_last_bit = (r_bit_cnt == c_last_bit);
    assign w_can_load = r_buf_full && (clk_per_bit != '0);
    assign w_accept   = tx_valid && !r_buf_full;

    assign tx_ready = ~r_buf_full;
    assign busy     = (r_state != c_idle);
    assign tx       = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_load marks the edge where the buffered byte becomes the active frame
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_can_load) begin
                    w_state_nxt = c_start;
                    w_load      = 1'b1;
                end
            end
            c_start: begin
                if (w_bit_end) w_state_nxt = c_data;
            end
            c_data: begin
                if (w_bit_end && w_last_bit) w_state_nxt = c_stop;
            end
            c_stop: begin
                if (w_bit_end) begin
                    if (w_can_load) begin
                        w_state_nxt = c_start;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        if (w_load) begin
            w_shift_nxt = r_buf;
            w_tx_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_start: begin
                    if (w_bit_end) w_tx_nxt = r_shift[0];
                end
                c_data: begin
                    if (w_bit_end) begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = w_last_bit ? 1'b1 : w_shift_nxt[0];
                    end
                end
                c_stop: begin
                    if (w_bit_end) w_tx_nxt = 1'b1;
                end
                default: w_tx_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_period   <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;

            // accept and load never coincide: load needs a full buffer
            if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            if (w_load) begin
                r_period   <= clk_per_bit;
                r_bit_cnt  <= '0;
                r_baud_cnt <= '0;
            end else if (r_state != c_idle) begin
                if (w_bit_end) begin
                    r_baud_cnt <= '0;
                    if (r_state == c_data) r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                end else begin
                    r_baud_cnt <= r_baud_cnt + CPB_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx; expected line levels come from
//            the frame definition (bit index = cycle offset / P).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB_W  = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CPB_W-1:0]  clk_per_bit;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx;
    logic              busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CPB_W(CPB_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_per_bit (clk_per_bit),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level k cycles after the start bit begins: slot 0 start, 1..8 data LSB first, 9 stop
    function automatic logic exp_line(input logic [7:0] b, input int p, input int k);
        int slot;
        slot = k / p;
        if (slot == 0) return 1'b0;
        if (slot <= DATA_W) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic offer(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, "_tx"},    tx,       1);
        check({tag, "_busy"},  busy,     0);
        check({tag, "_ready"}, tx_ready, exp_ready);
    endtask

    // Checks a frame whose start bit begins at the next edge, optionally
    // offering a follow-on byte, a rejected byte, or a clk_per_bit change.
    task automatic run_frame(input logic [7:0] b, input int p, input int ncyc,
                             input int pend_at, input logic [7:0] pend_d,
                             input int bp_at, input int newp_at, input int newp);
        for (int k = 0; k < ncyc; k++) begin
            tick();
            check($sformatf("tx_%02h_k%0d", b, k), tx, exp_line(b, p, k));
            check("busy_in_frame", busy, 1);
            if (k == 0) check("ready_at_start", tx_ready, 1);
            if (pend_at >= 0 && k == pend_at + 1) check("ready_after_accept", tx_ready, 0);
            tx_valid = 1'b0;
            if (k == pend_at) begin
                tx_valid = 1'b1;
                tx_data  = pend_d;
            end
            if (bp_at >= 0 && (k == bp_at || k == bp_at + 1)) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (k == newp_at) clk_per_bit = CPB_W'(newp);
        end
    endtask

    initial begin
        logic [7:0] b1;
        logic [7:0] b2;
        int         p;

        rst_n       = 1'b0;
        clk_per_bit = CPB_W'(4);
        tx_valid    = 1'b0;
        tx_data     = '0;
        repeat (3) tick();
        check_idle("reset", 1);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 1);

        // Basic frame, P=4
        offer(8'hA5);
        check_idle("accepted_not_started", 0);
        run_frame(8'hA5, 4, 40, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("basic_end", 1);

        // Back-to-back at P=8 with a rejected byte while the buffer is full
        clk_per_bit = CPB_W'(8);
        offer(8'h00);
        run_frame(8'h00, 8, 80, 10, 8'hFF, 30, -1, 0);
        tx_valid = 1'b0;
        run_frame(8'hFF, 8, 80, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("b2b_end", 1);

        // Byte offered on the last STOP cycle starts one idle cycle later
        clk_per_bit = CPB_W'(3);
        offer(8'h96);
        run_frame(8'h96, 3, 30, 29, 8'h3D, -1, -1, 0);
        tick();
        tx_valid = 1'b0;
        check_idle("last_stop_accept", 0);
        run_frame(8'h3D, 3, 30, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("last_stop_end", 1);

        // Disabled transmitter holds the byte until P becomes nonzero
        clk_per_bit = '0;
        offer(8'h12);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("disabled", 0);
        end
        clk_per_bit = CPB_W'(4);
        run_frame(8'h12, 4, 40, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("disable_end", 1);

        // Mid-frame P change only affects the following frame
        offer(8'h81);
        run_frame(8'h81, 4, 40, 30, 8'h5A, -1, 20, 12);
        tx_valid = 1'b0;
        run_frame(8'h5A, 12, 120, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("newp_end", 1);

        // Asynchronous reset during data bit 3
        clk_per_bit = CPB_W'(4);
        offer(8'h55);
        run_frame(8'h55, 4, 18, -1, 8'h00, -1, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 1);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("after_reset", 1);
        offer(8'h0F);
        run_frame(8'h0F, 4, 40, -1, 8'h00, -1, -1, 0);
        tick();
        check_idle("reset_recover_end", 1);

        // Random bytes and periods, each pair sent back-to-back
        for (int i = 0; i < 8; i++) begin
            p           = int'($urandom_range(1, 6));
            b1          = 8'($urandom);
            b2          = 8'($urandom);
            clk_per_bit = CPB_W'(p);
            offer(b1);
            run_frame(b1, p, 10 * p, int'($urandom_range(0, 10 * p - 2)), b2, -1, -1, 0);
            tx_valid = 1'b0;
            run_frame(b2, p, 10 * p, -1, 8'h00, -1, -1, 0);
            tick();
            check_idle("rand_end", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
